sqrt_arbiter: RTL and testbench

- Shares one `sqrt_int` square-root engine between NREQ requesters. Arbitration is round-robin.
- Each request is a valid/ready handshake carrying one radicand.
- The block pulses the engine's `start` and waits for completion. It then returns root, remainder, requester ID and an error flag on a single valid/ready response channel.
- A watchdog bounds the wait. Only one operation is in flight at a time.

---
 rtl/sqrt_arb_pkg.sv | 15 +
 rtl/sqrt_arbiter_if.sv | 39 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/sqrt_arbiter.sv | 124 ++++++++++++
 tb/tb_sqrt_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_arb_pkg.sv
// Shared types and default parameters for the square-root arbiter slice.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sqrt_arb_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Request, response and engine-side signals of the shared square-root arbiter.
interface sqrt_arbiter_if
    import sqrt_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    localparam int IDW  = $clog2(NREQ)
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_rad;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_root;
    logic [WIDTH-1:0]      resp_rem;
    logic                  resp_err;
    logic                  sq_start;
    logic [WIDTH-1:0]      sq_rad;
    logic                  sq_busy;
    logic                  sq_valid;
    logic [WIDTH-1:0]      sq_root;
    logic [WIDTH-1:0]      sq_rem;
    logic                  active;

    modport slave (
        input  req_valid, req_rad, resp_ready, sq_busy, sq_valid, sq_root, sq_rem,
        output req_ready, resp_valid, resp_id, resp_root, resp_rem, resp_err,
        output sq_start, sq_rad, active
    );

    modport master (
        output req_valid, req_rad, resp_ready, sq_busy, sq_valid, sq_root, sq_rem,
        input  req_ready, resp_valid, resp_id, resp_root, resp_rem, resp_err,
        input  sq_start, sq_rad, active
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_gnt, modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_gnt,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found_s;
    logic [IDW-1:0] cand_s;

    // Scan starting one past the previous winner so every requester gets a turn.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        if (enable) begin
            for (int i = 1; i <= NREQ; i++) begin
                cand_s = IDW'((int'(last_gnt) + i) % NREQ);
                if (req[cand_s] && !found_s) begin
                    found_s      = 1'b1;
                    gnt[cand_s]  = 1'b1;
                    gnt_idx      = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one iterative square-root engine, with a
// watchdog on the engine wait and a single valid/ready response channel.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IDW    = $clog2(NREQ)
) (
    input logic          clk,
    input logic          rst_n,
    sqrt_arbiter_if.slave bus
);

    localparam int WCW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [IDW-1:0]   last_gnt_r;
    logic [WCW-1:0]   wait_cnt_r;
    logic             sq_start_r;
    logic [WIDTH-1:0] sq_rad_r;
    logic             resp_valid_r;
    logic             resp_err_r;
    logic [IDW-1:0]   resp_id_r;
    logic [WIDTH-1:0] resp_root_r;
    logic [WIDTH-1:0] resp_rem_r;
    logic             active_r;

    logic [NREQ-1:0]  gnt_s;
    logic [IDW-1:0]   gnt_idx_s;
    logic             hs_s;
    logic             done_s;
    logic             timeout_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req      (bus.req_valid),
        .last_gnt (last_gnt_r),
        .enable   (rst_n && (state_r == S_IDLE)),
        .gnt      (gnt_s),
        .gnt_idx  (gnt_idx_s)
    );

    assign hs_s      = |gnt_s;
    // The engine's valid is sticky from the previous operation, so the first WAIT cycle is ignored.
    assign done_s    = (wait_cnt_r != '0) && bus.sq_valid && !bus.sq_busy;
    assign timeout_s = (wait_cnt_r == WCW'(TIMEOUT - 1));

    assign bus.req_ready  = gnt_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_root  = resp_root_r;
    assign bus.resp_rem   = resp_rem_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.sq_start   = sq_start_r;
    assign bus.sq_rad     = sq_rad_r;
    assign bus.active     = active_r;

    // Next-state decode of the controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  if (hs_s) state_nx_s = S_ISSUE; else state_nx_s = S_IDLE;
            S_ISSUE: state_nx_s = S_WAIT;
            S_WAIT:  if (done_s || timeout_s) state_nx_s = S_RESP; else state_nx_s = S_WAIT;
            S_RESP:  if (bus.resp_ready) state_nx_s = S_IDLE; else state_nx_s = S_RESP;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, datapath latches and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            last_gnt_r   <= IDW'(NREQ - 1);
            wait_cnt_r   <= '0;
            sq_start_r   <= 1'b0;
            sq_rad_r     <= '0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_id_r    <= '0;
            resp_root_r  <= '0;
            resp_rem_r   <= '0;
            active_r     <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            active_r     <= (state_nx_s != S_IDLE);
            sq_start_r   <= (state_nx_s == S_ISSUE);
            resp_valid_r <= (state_nx_s == S_RESP);
            case (state_r)
                S_IDLE: begin
                    if (hs_s) begin
                        sq_rad_r   <= bus.req_rad[gnt_idx_s*WIDTH +: WIDTH];
                        resp_id_r  <= gnt_idx_s;
                        last_gnt_r <= gnt_idx_s;
                    end
                end
                S_ISSUE: wait_cnt_r <= '0;
                S_WAIT: begin
                    if (done_s) begin
                        resp_root_r <= bus.sq_root;
                        resp_rem_r  <= bus.sq_rem;
                        resp_err_r  <= 1'b0;
                    end else if (timeout_s) begin
                        resp_root_r <= '0;
                        resp_rem_r  <= '0;
                        resp_err_r  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WCW'(1);
                    end
                end
                S_RESP: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt engine model.
module tb_sqrt_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int ITER    = WIDTH / 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sqrt_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    sqrt_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Engine model: no reset, sticky valid, optional hang and one-cycle-late load.
    logic [WIDTH-1:0] eng_rad   = '0;
    logic [WIDTH-1:0] eng_root  = '0;
    logic [WIDTH-1:0] eng_rem   = '0;
    logic             eng_busy  = 1'b0;
    logic             eng_valid = 1'b0;
    logic             eng_pend  = 1'b0;
    int               eng_cnt   = 0;
    bit               hang      = 1'b0;
    bit               lazy      = 1'b0;

    assign bus.sq_busy  = eng_busy;
    assign bus.sq_valid = eng_valid;
    assign bus.sq_root  = eng_root;
    assign bus.sq_rem   = eng_rem;

    function automatic logic [WIDTH-1:0] isqrt(input logic [WIDTH-1:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return WIDTH'(r);
    endfunction

    function automatic logic [WIDTH-1:0] isrem(input logic [WIDTH-1:0] x);
        int r = int'(isqrt(x));
        return WIDTH'(int'(x) - r * r);
    endfunction

    always @(posedge clk) begin
        if (bus.sq_start) begin
            eng_rad <= bus.sq_rad;
            eng_cnt <= 0;
            if (lazy) begin
                eng_pend <= 1'b1;
            end else begin
                eng_busy  <= 1'b1;
                eng_valid <= 1'b0;
            end
        end else if (eng_pend) begin
            eng_pend  <= 1'b0;
            eng_busy  <= 1'b1;
            eng_valid <= 1'b0;
        end else if (eng_busy && !hang) begin
            if (eng_cnt == ITER - 1) begin
                eng_busy  <= 1'b0;
                eng_valid <= 1'b1;
                eng_root  <= isqrt(eng_rad);
                eng_rem   <= isrem(eng_rad);
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Run log filled by run_bus
    int rsp_id[16], rsp_root[16], rsp_rem[16], rsp_err[16], rsp_cyc[16];
    int gnt_log[16], gnt_cyc[16];
    int n_rsp, n_gnt, n_start, start_cyc, start_rad;
    bit onehot_bad;

    task automatic set_req(input int k, input int rad);
        bus.req_rad[k*WIDTH +: WIDTH] = WIDTH'(rad);
        bus.req_valid[k] = 1'b1;
    endtask

    task automatic apply_reset();
        bus.req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Clock the bus until `want` responses are taken or max_cyc elapses; cycle 0 is the entry cycle.
    task automatic run_bus(input int want, input int max_cyc, input bit drop);
        logic [NREQ-1:0] hs;
        int c = 0;
        n_rsp = 0; n_gnt = 0; n_start = 0; start_cyc = -1; start_rad = -1; onehot_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rsp_id[i] = -1; rsp_root[i] = -1; rsp_rem[i] = -1; rsp_err[i] = -1; rsp_cyc[i] = -1;
            gnt_log[i] = -1; gnt_cyc[i] = -1;
        end
        while (n_rsp < want && c < max_cyc) begin
            #1;
            hs = bus.req_ready & bus.req_valid;
            if ($countones(bus.req_ready) > 1) onehot_bad = 1'b1;
            if (hs != '0 && n_gnt < 16) begin
                for (int k = 0; k < NREQ; k++) if (hs[k]) gnt_log[n_gnt] = k;
                gnt_cyc[n_gnt] = c;
                n_gnt++;
            end
            if (bus.sq_start) begin
                n_start++;
                start_cyc = c;
                start_rad = int'(bus.sq_rad);
            end
            if (bus.resp_valid && bus.resp_ready && n_rsp < 16) begin
                rsp_id[n_rsp]   = int'(bus.resp_id);
                rsp_root[n_rsp] = int'(bus.resp_root);
                rsp_rem[n_rsp]  = int'(bus.resp_rem);
                rsp_err[n_rsp]  = int'(bus.resp_err);
                rsp_cyc[n_rsp]  = c;
                n_rsp++;
            end
            @(posedge clk);
            #1;
            if (drop) bus.req_valid = bus.req_valid & ~hs;
            c++;
        end
    endtask

    task automatic test_reset();
        set_req(0, 1); set_req(1, 4); set_req(2, 9); set_req(3, 16);
        #12;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if ({bus.resp_valid, bus.sq_start, bus.active, bus.resp_err} !== 4'b0000) begin failures++;
            $display("FAIL reset_ctrl: got valid/start/active/err=%b expected 0000", {bus.resp_valid, bus.sq_start, bus.active, bus.resp_err}); end
        checks++; if ({bus.resp_id, bus.resp_root, bus.resp_rem, bus.sq_rad} !== '0) begin failures++;
            $display("FAIL reset_data: got id=%0d root=%0d rem=%0d sq_rad=%0d expected all 0", bus.resp_id, bus.resp_root, bus.resp_rem, bus.sq_rad); end
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.resp_ready = 1'b1;
        set_req(0, 49);
        run_bus(1, 30, 1'b1);
        checks++; if (n_rsp !== 1) begin failures++; $display("FAIL single_done: got %0d responses expected 1", n_rsp); end
        checks++; if (gnt_log[0] !== 0 || gnt_cyc[0] !== 0) begin failures++; $display("FAIL single_grant: got req %0d at cycle %0d expected req 0 at cycle 0", gnt_log[0], gnt_cyc[0]); end
        checks++; if (n_start !== 1 || start_cyc !== 1) begin failures++; $display("FAIL single_start: got %0d pulses last at cycle %0d expected 1 at cycle 1", n_start, start_cyc); end
        checks++; if (start_rad !== 49) begin failures++; $display("FAIL single_sq_rad: got %0d expected 49", start_rad); end
        checks++; if (rsp_cyc[0] !== 7) begin failures++; $display("FAIL single_latency: got cycle %0d expected 7", rsp_cyc[0]); end
        checks++; if (rsp_id[0] !== 0 || rsp_root[0] !== 7 || rsp_rem[0] !== 0 || rsp_err[0] !== 0) begin failures++;
            $display("FAIL single_resp: got id=%0d root=%0d rem=%0d err=%0d expected 0/7/0/0", rsp_id[0], rsp_root[0], rsp_rem[0], rsp_err[0]); end
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.active !== 1'b0) begin failures++;
            $display("FAIL single_return_idle: got valid=%b active=%b expected 0 0", bus.resp_valid, bus.active); end
    endtask

    task automatic test_two_reqs();
        apply_reset();
        set_req(0, 200); set_req(2, 255);
        run_bus(2, 60, 1'b1);
        checks++; if (n_rsp !== 2) begin failures++; $display("FAIL two_done: got %0d responses expected 2", n_rsp); end
        checks++; if (onehot_bad !== 1'b0) begin failures++; $display("FAIL two_onehot: req_ready had more than one bit set"); end
        checks++; if (rsp_id[0] !== 0 || rsp_root[0] !== 14 || rsp_rem[0] !== 4) begin failures++;
            $display("FAIL two_first: got id=%0d root=%0d rem=%0d expected 0/14/4", rsp_id[0], rsp_root[0], rsp_rem[0]); end
        checks++; if (rsp_id[1] !== 2 || rsp_root[1] !== 15 || rsp_rem[1] !== 30) begin failures++;
            $display("FAIL two_second: got id=%0d root=%0d rem=%0d expected 2/15/30", rsp_id[1], rsp_root[1], rsp_rem[1]); end
    endtask

    task automatic test_round_robin();
        int exp_root[4] = '{4, 5, 6, 9};
        apply_reset();
        set_req(0, 16); set_req(1, 25); set_req(2, 36); set_req(3, 81);
        run_bus(8, 200, 1'b0);
        bus.req_valid = '0;
        checks++; if (n_rsp !== 8) begin failures++; $display("FAIL rr_done: got %0d responses expected 8", n_rsp); end
        checks++; if (onehot_bad !== 1'b0) begin failures++; $display("FAIL rr_onehot: req_ready had more than one bit set"); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rsp_id[i] !== i % 4 || rsp_root[i] !== exp_root[i % 4]) begin failures++;
                $display("FAIL rr_order[%0d]: got id=%0d root=%0d expected id=%0d root=%0d", i, rsp_id[i], rsp_root[i], i % 4, exp_root[i % 4]); end
        end
    endtask

    task automatic test_timeout();
        hang = 1'b1;
        set_req(1, 100);
        run_bus(1, 60, 1'b1);
        hang = 1'b0;
        checks++; if (rsp_cyc[0] !== TIMEOUT + 2) begin failures++; $display("FAIL timeout_cycle: got cycle %0d expected %0d", rsp_cyc[0], TIMEOUT + 2); end
        checks++; if (rsp_id[0] !== 1 || rsp_root[0] !== 0 || rsp_rem[0] !== 0 || rsp_err[0] !== 1) begin failures++;
            $display("FAIL timeout_resp: got id=%0d root=%0d rem=%0d err=%0d expected 1/0/0/1", rsp_id[0], rsp_root[0], rsp_rem[0], rsp_err[0]); end
        set_req(3, 144);
        run_bus(1, 30, 1'b1);
        checks++; if (rsp_id[0] !== 3 || rsp_root[0] !== 12 || rsp_rem[0] !== 0 || rsp_err[0] !== 0 || rsp_cyc[0] !== 7) begin failures++;
            $display("FAIL timeout_recover: got id=%0d root=%0d rem=%0d err=%0d cycle=%0d expected 3/12/0/0 cycle 7",
                     rsp_id[0], rsp_root[0], rsp_rem[0], rsp_err[0], rsp_cyc[0]); end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] hs;
        int  c = 0;
        bit  got = 1'b0;
        bit  field_bad = 1'b0;
        bit  rdy_bad = 1'b0;
        bit  start_seen = 1'b0;
        bus.resp_ready = 1'b0;
        set_req(2, 64);
        while (!got && c < 30) begin
            #1;
            hs = bus.req_ready & bus.req_valid;
            if (bus.resp_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                bus.req_valid = bus.req_valid & ~hs;
                c++;
            end
        end
        checks++; if (!got) begin failures++; $display("FAIL bp_resp: got no resp_valid within 30 cycles expected one"); end
        set_req(3, 9);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_root !== 8'd8 || bus.resp_rem !== 8'd0 || bus.resp_err !== 1'b0) field_bad = 1'b1;
            if (bus.req_ready !== 4'b0000) rdy_bad = 1'b1;
            if (bus.sq_start) start_seen = 1'b1;
        end
        checks++; if (field_bad) begin failures++; $display("FAIL bp_hold: got id=%0d root=%0d rem=%0d valid=%b expected held 2/8/0/1", bus.resp_id, bus.resp_root, bus.resp_rem, bus.resp_valid); end
        checks++; if (rdy_bad) begin failures++; $display("FAIL bp_req_ready: got nonzero req_ready expected 0000 while stalled"); end
        checks++; if (start_seen) begin failures++; $display("FAIL bp_start: got sq_start while stalled expected none"); end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (bus.resp_valid !== 1'b0 || bus.active !== 1'b0 || bus.req_ready !== 4'b1000) begin failures++;
            $display("FAIL bp_release: got valid=%b active=%b req_ready=%b expected 0 0 1000", bus.resp_valid, bus.active, bus.req_ready); end
        run_bus(1, 30, 1'b1);
        checks++; if (rsp_id[0] !== 3 || rsp_root[0] !== 3 || rsp_rem[0] !== 0) begin failures++;
            $display("FAIL bp_next: got id=%0d root=%0d rem=%0d expected 3/3/0", rsp_id[0], rsp_root[0], rsp_rem[0]); end
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 1'b1;
        set_req(0, 49);
        #1;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.active !== 1'b1) begin failures++; $display("FAIL mid_active: got %b expected 1 during WAIT", bus.active); end
        set_req(1, 81);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.active, bus.sq_start, bus.resp_valid, bus.resp_err} !== 4'b0000 || bus.sq_rad !== 8'd0 || bus.req_ready !== 4'b0000) begin failures++;
            $display("FAIL mid_reset: got active=%b start=%b valid=%b err=%b sq_rad=%0d req_ready=%b expected all 0",
                     bus.active, bus.sq_start, bus.resp_valid, bus.resp_err, bus.sq_rad, bus.req_ready); end
        repeat (6) @(posedge clk);
        #1;
        bus.req_valid = '0;
        lazy = 1'b1;
        rst_n = 1'b1;
        set_req(0, 0);
        run_bus(1, 30, 1'b1);
        lazy = 1'b0;
        checks++; if (rsp_id[0] !== 0 || rsp_root[0] !== 0 || rsp_rem[0] !== 0 || rsp_err[0] !== 0) begin failures++;
            $display("FAIL mid_stale: got id=%0d root=%0d rem=%0d err=%0d expected 0/0/0/0", rsp_id[0], rsp_root[0], rsp_rem[0], rsp_err[0]); end
        checks++; if (rsp_cyc[0] !== 8) begin failures++; $display("FAIL mid_latency: got cycle %0d expected 8", rsp_cyc[0]); end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_rad    = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_two_reqs();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
